// File: rtl/tlm_pkg.sv
// Shared lamp encodings, phase codes, monitor states and phase lamp patterns
// for the traffic light monitor.
package tlm_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [2:0] PH_NONE = 3'd0;
  localparam logic [2:0] PH_P1   = 3'd1;
  localparam logic [2:0] PH_P2   = 3'd2;
  localparam logic [2:0] PH_P3   = 3'd3;
  localparam logic [2:0] PH_P4   = 3'd4;
  localparam logic [2:0] PH_P5   = 3'd5;
  localparam logic [2:0] PH_P6   = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    TRACK = 2'd2
  } mon_state_e;

  // Lamp patterns packed as {M1, M2, MT, S}.
  localparam logic [11:0] PAT_P1 = {LAMP_GRN, LAMP_GRN, LAMP_RED, LAMP_RED};
  localparam logic [11:0] PAT_P2 = {LAMP_GRN, LAMP_YEL, LAMP_RED, LAMP_RED};
  localparam logic [11:0] PAT_P3 = {LAMP_GRN, LAMP_RED, LAMP_GRN, LAMP_RED};
  localparam logic [11:0] PAT_P4 = {LAMP_YEL, LAMP_RED, LAMP_YEL, LAMP_RED};
  localparam logic [11:0] PAT_P5 = {LAMP_RED, LAMP_RED, LAMP_RED, LAMP_GRN};
  localparam logic [11:0] PAT_P6 = {LAMP_RED, LAMP_RED, LAMP_RED, LAMP_YEL};

  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    return (ph == PH_P6) ? PH_P1 : ph + 3'd1;
  endfunction

endpackage

// File: rtl/tlm_phase_decode.sv
// Combinational decode of the four lamp buses into a phase number plus
// encoding and conflicting-movement indications.
module tlm_phase_decode
  import tlm_pkg::*;
(
  input  logic [2:0] lamp_m1,
  input  logic [2:0] lamp_m2,
  input  logic [2:0] lamp_mt,
  input  logic [2:0] lamp_s,
  output logic [2:0] phase,
  output logic       encoding_bad,
  output logic       conflict
);

  function automatic logic lamp_ok(input logic [2:0] lamp);
    return (lamp == LAMP_RED) || (lamp == LAMP_YEL) || (lamp == LAMP_GRN);
  endfunction

  logic [11:0] pattern;

  always_comb begin
    pattern      = {lamp_m1, lamp_m2, lamp_mt, lamp_s};
    encoding_bad = !(lamp_ok(lamp_m1) && lamp_ok(lamp_m2) &&
                     lamp_ok(lamp_mt) && lamp_ok(lamp_s));
    // Side street against any main movement, or turn against oncoming M2.
    conflict     = ((lamp_s != LAMP_RED) &&
                    ((lamp_m1 != LAMP_RED) || (lamp_m2 != LAMP_RED) ||
                     (lamp_mt != LAMP_RED))) ||
                   ((lamp_mt != LAMP_RED) && (lamp_m2 != LAMP_RED));
    phase        = PH_NONE;
    if (!encoding_bad) begin
      case (pattern)
        PAT_P1:  phase = PH_P1;
        PAT_P2:  phase = PH_P2;
        PAT_P3:  phase = PH_P3;
        PAT_P4:  phase = PH_P4;
        PAT_P5:  phase = PH_P5;
        PAT_P6:  phase = PH_P6;
        default: phase = PH_NONE;
      endcase
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive two-stage checker for the intersection lamp interface.
// Dwell-time checking is built only when TLM_DWELL_CHECK_EN is defined.
module traffic_light_monitor
  import tlm_pkg::*;
#(
  parameter int unsigned DWELL_P1 = 11,
  parameter int unsigned DWELL_P2 = 11,
  parameter int unsigned DWELL_P3 = 6,
  parameter int unsigned DWELL_P4 = 11,
  parameter int unsigned DWELL_P5 = 4,
  parameter int unsigned DWELL_P6 = 11,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [2:0]       light_M1,
  input  logic [2:0]       light_M2,
  input  logic [2:0]       light_MT,
  input  logic [2:0]       light_S,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic             err_encoding,
  output logic             err_conflict,
  output logic             err_sequence,
  output logic             err_dwell,
  output logic             err_any,
  output logic [CNT_W-1:0] cycle_count,
  output logic [7:0]       fault_count
);

  logic [2:0] m1_p1_q, m2_p1_q, mt_p1_q, s_p1_q;
  logic [2:0] cur_phase;
  logic       enc_bad, conflict;

  // Stage 1: sample the lamp buses; idle value is all-red.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_p1_q <= LAMP_RED;
      m2_p1_q <= LAMP_RED;
      mt_p1_q <= LAMP_RED;
      s_p1_q  <= LAMP_RED;
    end else begin
      m1_p1_q <= light_M1;
      m2_p1_q <= light_M2;
      mt_p1_q <= light_MT;
      s_p1_q  <= light_S;
    end
  end

  tlm_phase_decode u_decode (
    .lamp_m1      (m1_p1_q),
    .lamp_m2      (m2_p1_q),
    .lamp_mt      (mt_p1_q),
    .lamp_s       (s_p1_q),
    .phase        (cur_phase),
    .encoding_bad (enc_bad),
    .conflict     (conflict)
  );

  mon_state_e       state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic             err_enc_q, err_enc_d;
  logic             err_conf_q, err_conf_d;
  logic             err_seq_q, err_seq_d;
  logic             err_dwell_q, err_dwell_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [7:0]       fault_cnt_q, fault_cnt_d;
  logic [7:0]       fault_base;
  logic             changed, legal, fire_seq, fire_dwell, fire_any, cycle_inc;

`ifdef TLM_DWELL_CHECK_EN
  logic [CNT_W-1:0] dwell_q, dwell_d;

  function automatic logic [CNT_W-1:0] dwell_of(input logic [2:0] ph);
    case (ph)
      PH_P1:   return CNT_W'(DWELL_P1);
      PH_P2:   return CNT_W'(DWELL_P2);
      PH_P3:   return CNT_W'(DWELL_P3);
      PH_P4:   return CNT_W'(DWELL_P4);
      PH_P5:   return CNT_W'(DWELL_P5);
      PH_P6:   return CNT_W'(DWELL_P6);
      default: return '0;
    endcase
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = cur_phase;
    fire_seq   = 1'b0;
    fire_dwell = 1'b0;
    cycle_inc  = 1'b0;
    changed    = (cur_phase != phase_q);
    legal      = changed && (phase_q != PH_NONE) &&
                 (cur_phase == next_phase(phase_q));
`ifdef TLM_DWELL_CHECK_EN
    // Counts samples of the current phase; the first sample counts as 1.
    if (changed)
      dwell_d = CNT_W'(1);
    else if (dwell_q == '1)
      dwell_d = dwell_q;
    else
      dwell_d = dwell_q + CNT_W'(1);
`endif
    case (state_q)
      IDLE:  if (cur_phase != PH_NONE) state_d = ALIGN;
      ALIGN: if (legal) state_d = TRACK;
      TRACK: begin
        if (changed) begin
          if (!legal)
            fire_seq = 1'b1;
          else if (phase_q == PH_P6)
            cycle_inc = 1'b1;
        end
`ifdef TLM_DWELL_CHECK_EN
        // On a change the old phase must have lasted exactly its dwell;
        // without a change, reaching the dwell once more means overstay.
        if (changed)
          fire_dwell = (dwell_q != dwell_of(phase_q));
        else
          fire_dwell = (dwell_q == dwell_of(phase_q));
`endif
      end
      default: state_d = IDLE;
    endcase

    fire_any = enc_bad | conflict | fire_seq | fire_dwell;
    if (fire_any && (state_q != IDLE))
      state_d = ALIGN;

    err_enc_d   = (err_enc_q   & ~clr) | enc_bad;
    err_conf_d  = (err_conf_q  & ~clr) | conflict;
    err_seq_d   = (err_seq_q   & ~clr) | fire_seq;
    err_dwell_d = (err_dwell_q & ~clr) | fire_dwell;

    fault_base  = clr ? 8'd0 : fault_cnt_q;
    fault_cnt_d = (fire_any && (fault_base != 8'hFF)) ? fault_base + 8'd1
                                                      : fault_base;
    cycle_cnt_d = cycle_inc ? cycle_cnt_q + CNT_W'(1) : cycle_cnt_q;
  end

  // Stage 2: decoded phase, monitor state, sticky flags and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= PH_NONE;
      err_enc_q   <= 1'b0;
      err_conf_q  <= 1'b0;
      err_seq_q   <= 1'b0;
      err_dwell_q <= 1'b0;
      cycle_cnt_q <= '0;
      fault_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      err_enc_q   <= err_enc_d;
      err_conf_q  <= err_conf_d;
      err_seq_q   <= err_seq_d;
      err_dwell_q <= err_dwell_d;
      cycle_cnt_q <= cycle_cnt_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

`ifdef TLM_DWELL_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dwell_q <= '0;
    else     dwell_q <= dwell_d;
  end
`endif

  assign phase        = phase_q;
  assign phase_valid  = (state_q == TRACK);
  assign err_encoding = err_enc_q;
  assign err_conflict = err_conf_q;
  assign err_sequence = err_seq_q;
  assign err_dwell    = err_dwell_q;
  assign err_any      = err_enc_q | err_conf_q | err_seq_q | err_dwell_q;
  assign cycle_count  = cycle_cnt_q;
  assign fault_count  = fault_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: decode vector table plus
// hand-written multi-cycle sequences for tracking, faults and counters.
module tb_traffic_light_monitor;

  localparam int CNT_W = 16;
`ifdef TLM_DWELL_CHECK_EN
  localparam logic DWELL_EN = 1'b1;
`else
  localparam logic DWELL_EN = 1'b0;
`endif

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic             clk, rst, clr;
  logic [2:0]       light_M1, light_M2, light_MT, light_S;
  logic [2:0]       phase;
  logic             phase_valid, err_encoding, err_conflict, err_sequence;
  logic             err_dwell, err_any;
  logic [CNT_W-1:0] cycle_count;
  logic [7:0]       fault_count;

  int total = 0;
  int bad   = 0;

  traffic_light_monitor #(
    .DWELL_P1(11), .DWELL_P2(11), .DWELL_P3(6),
    .DWELL_P4(11), .DWELL_P5(4),  .DWELL_P6(11), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .light_M1     (light_M1),
    .light_M2     (light_M2),
    .light_MT     (light_MT),
    .light_S      (light_S),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .err_encoding (err_encoding),
    .err_conflict (err_conflict),
    .err_sequence (err_sequence),
    .err_dwell    (err_dwell),
    .err_any      (err_any),
    .cycle_count  (cycle_count),
    .fault_count  (fault_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] m1, m2, mt, s;
    logic [2:0] ph;
    logic       enc, conf;
  } vec_t;

  vec_t vecs[14];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] c, input logic [2:0] d);
    light_M1 = a;
    light_M2 = b;
    light_MT = c;
    light_S  = d;
  endtask

  task automatic drive_ph(input int p);
    case (p)
      1:       drive(G, G, R, R);
      2:       drive(G, Y, R, R);
      3:       drive(G, R, G, R);
      4:       drive(Y, R, Y, R);
      5:       drive(R, R, R, G);
      6:       drive(R, R, R, Y);
      default: drive(R, R, R, R);
    endcase
  endtask

  function automatic int dwell(input int p);
    case (p)
      3:       return 6;
      5:       return 4;
      default: return 11;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b0;
    drive(R, R, R, R);
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    vecs[0]  = '{G, G, R, R, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{G, Y, R, R, 3'd2, 1'b0, 1'b0};
    vecs[2]  = '{G, R, G, R, 3'd3, 1'b0, 1'b0};
    vecs[3]  = '{Y, R, Y, R, 3'd4, 1'b0, 1'b0};
    vecs[4]  = '{R, R, R, G, 3'd5, 1'b0, 1'b0};
    vecs[5]  = '{R, R, R, Y, 3'd6, 1'b0, 1'b0};
    vecs[6]  = '{R, R, R, R, 3'd0, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, R, R, R, 3'd0, 1'b1, 1'b0};
    vecs[8]  = '{G, R, R, G, 3'd0, 1'b0, 1'b1};
    vecs[9]  = '{R, G, G, R, 3'd0, 1'b0, 1'b1};
    vecs[10] = '{3'b000, R, R, R, 3'd0, 1'b1, 1'b0};
    vecs[11] = '{G, G, R, Y, 3'd0, 1'b0, 1'b1};
    vecs[12] = '{Y, R, R, R, 3'd0, 1'b0, 1'b0};
    vecs[13] = '{3'b111, R, R, R, 3'd0, 1'b1, 1'b0};

    rst = 1'b1;
    clr = 1'b0;
    drive(R, R, R, R);
    #12;
    check("rst_phase", 32'(phase), 0);
    check("rst_valid", 32'(phase_valid), 0);
    check("rst_err_any", 32'(err_any), 0);
    check("rst_fault_count", 32'(fault_count), 0);
    check("rst_cycle_count", 32'(cycle_count), 0);
    step(1);
    rst = 1'b0;
    step(1);

    // Single-pattern decode table, fresh reset per vector.
    for (int i = 0; i < 14; i++) begin
      do_reset();
      drive(vecs[i].m1, vecs[i].m2, vecs[i].mt, vecs[i].s);
      step(1);
      check($sformatf("v%0d_phase_lat", i), 32'(phase), 0);
      step(1);
      check($sformatf("v%0d_phase", i), 32'(phase), 32'(vecs[i].ph));
      check($sformatf("v%0d_enc", i), 32'(err_encoding), 32'(vecs[i].enc));
      check($sformatf("v%0d_conf", i), 32'(err_conflict), 32'(vecs[i].conf));
      check($sformatf("v%0d_any", i), 32'(err_any),
            32'(vecs[i].enc | vecs[i].conf));
      check($sformatf("v%0d_faults", i), 32'(fault_count),
            32'(vecs[i].enc | vecs[i].conf));
    end

    // Two full legal cycles from P1.
    do_reset();
    drive_ph(1);
    step(11);
    drive_ph(2);
    step(1);
    check("track_not_yet", 32'(phase_valid), 0);
    step(1);
    check("track_entered", 32'(phase_valid), 1);
    step(9);
    for (int p = 3; p <= 6; p++) begin
      drive_ph(p);
      step(dwell(p));
    end
    for (int p = 1; p <= 6; p++) begin
      drive_ph(p);
      step(dwell(p));
    end
    drive_ph(1);
    step(3);
    check("cyc_phase", 32'(phase), 1);
    check("cyc_count", 32'(cycle_count), 2);
    check("cyc_err_any", 32'(err_any), 0);
    check("cyc_faults", 32'(fault_count), 0);
    check("cyc_valid", 32'(phase_valid), 1);

    // P3 cut short by one cycle, then too-long P5.
    step(8);
    drive_ph(2);
    step(11);
    drive_ph(3);
    step(5);
    drive_ph(4);
    step(1);
    check("short_dwell_early", 32'(err_dwell), 0);
    step(1);
    check("short_dwell", 32'(err_dwell), 32'(DWELL_EN));
    check("short_faults", 32'(fault_count), 32'(DWELL_EN));
    check("short_valid", 32'(phase_valid), 32'(!DWELL_EN));
    check("short_seq", 32'(err_sequence), 0);
    check("short_phase", 32'(phase), 4);
    step(9);
    drive_ph(5);
    step(2);
    check("retrack_valid", 32'(phase_valid), 1);
    step(4);
    check("long_faults", 32'(fault_count), DWELL_EN ? 32'd2 : 32'd0);
    check("long_valid", 32'(phase_valid), 32'(!DWELL_EN));
    step(3);
    check("long_once", 32'(fault_count), DWELL_EN ? 32'd2 : 32'd0);

    // Skip P2 -> P4 with correct P2 dwell.
    do_reset();
    drive_ph(1);
    step(3);
    drive_ph(2);
    step(11);
    drive_ph(4);
    step(2);
    check("skip_seq", 32'(err_sequence), 1);
    check("skip_dwell", 32'(err_dwell), 0);
    check("skip_phase", 32'(phase), 4);
    check("skip_faults", 32'(fault_count), 1);
    check("skip_valid", 32'(phase_valid), 0);

    // clr coinciding with a new conflict, then saturation.
    do_reset();
    drive(3'b011, R, R, R);
    step(1);
    drive(R, R, R, R);
    step(3);
    check("pre_clr_enc", 32'(err_encoding), 1);
    check("pre_clr_faults", 32'(fault_count), 1);
    drive(G, R, R, G);
    step(1);
    drive(R, R, R, R);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_conf", 32'(err_conflict), 1);
    check("clr_enc", 32'(err_encoding), 0);
    check("clr_faults", 32'(fault_count), 1);
    check("clr_any", 32'(err_any), 1);
    drive(G, R, R, G);
    step(302);
    check("sat_faults", 32'(fault_count), 255);
    drive(R, R, R, R);
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_only_faults", 32'(fault_count), 0);
    check("clr_only_any", 32'(err_any), 0);

    // Asynchronous reset in the middle of P4.
    do_reset();
    drive_ph(1);
    step(3);
    drive_ph(2);
    step(11);
    drive_ph(3);
    step(6);
    drive_ph(4);
    step(5);
    check("mid_p4_phase", 32'(phase), 4);
    check("mid_p4_valid", 32'(phase_valid), 1);
    rst = 1'b1;
    #1;
    check("arst_phase", 32'(phase), 0);
    check("arst_valid", 32'(phase_valid), 0);
    check("arst_any", 32'(err_any), 0);
    check("arst_faults", 32'(fault_count), 0);
    check("arst_cycles", 32'(cycle_count), 0);
    step(1);
    rst = 1'b0;
    step(2);
    check("post_rst_phase", 32'(phase), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
